// File: rtl/alu32_defs.sv
// Shared ALU opcodes, condition codes, flag bit positions and the condition evaluator.
package alu32_defs;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int RSP_W = 37;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc)
            CC_EQ:   r = z;
            CC_NE:   r = !z;
            CC_CS:   r = c;
            CC_CC:   r = !c;
            CC_MI:   r = n;
            CC_PL:   r = !n;
            CC_VS:   r = v;
            CC_VC:   r = !v;
            CC_HI:   r = c & !z;
            CC_LS:   r = !c | z;
            CC_GE:   r = (n == v);
            CC_LT:   r = (n != v);
            CC_GT:   r = !z & (n == v);
            CC_LE:   r = z | (n != v);
            CC_AL:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU with NZCV flags; C is carry-out for add and no-borrow for sub,
// and C/V are zero for logic ops.
module alu32
    import alu32_defs::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_n,
    output logic        o_z,
    output logic        o_c,
    output logic        o_v
);

    logic [32:0] w_sum;
    logic [32:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;

    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (i_op)
            OP_NOTA: o_result = ~i_a;
            OP_NOTB: o_result = ~i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_ADD: begin
                o_result = w_sum[31:0];
                o_c      = w_sum[32];
                o_v      = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            default: begin
                o_result = w_dif[31:0];
                o_c      = w_dif[32];
                o_v      = (i_a[31] != i_b[31]) && (w_dif[31] != i_a[31]);
            end
        endcase
        o_n = o_result[31];
        o_z = (o_result == 32'd0);
    end

endmodule

// File: rtl/alu32_rsp_fifo.sv
// Synchronous FIFO for ALU responses; push while full is only taken with a same-cycle pop.
// Head data reads as zero when empty so the response port is clean between bursts.
module alu32_rsp_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == FULL_CNT);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu32_seq.sv
// Sequential ALU front-end: accept in IDLE, execute and push a response one edge later.
// Stalls in EXEC (cmd_ready low) while the response FIFO is full and not being popped.
module alu32_seq
    import alu32_defs::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] ACC_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic        cmd_use_acc,
    input  logic        cmd_wr_acc,
    input  logic        cmd_setf,
    input  logic [3:0]  cmd_cond,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_cond,
    output logic [31:0] acc_q,
    output logic [3:0]  flags_q
);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_wr_acc;
    logic        r_setf;
    logic [3:0]  r_cond;
    logic [31:0] r_acc;
    logic [3:0]  r_flags;

    logic [31:0]      w_alu_res;
    logic             w_n, w_z, w_c, w_v;
    logic [3:0]       w_alu_flags;
    logic [3:0]       w_eff_flags;
    logic             w_cond_out;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [RSP_W-1:0] w_head;

    alu32 u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_res),
        .o_n      (w_n),
        .o_z      (w_z),
        .o_c      (w_c),
        .o_v      (w_v)
    );

    assign w_alu_flags = {w_n, w_z, w_c, w_v};
    // A flag-setting op is judged on its own fresh flags, not the stale register.
    assign w_eff_flags = r_setf ? w_alu_flags : r_flags;
    assign w_cond_out  = cond_eval(r_cond, w_eff_flags);
    assign w_pop       = rsp_valid && rsp_ready && !clr;
    assign w_accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = !clr;
                if (cmd_valid && !clr) w_next_state = ST_EXEC;
            end
            default: begin
                if (!clr && (!w_fifo_full || w_pop)) begin
                    w_push       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
        endcase
        if (clr) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_wr_acc <= 1'b0;
            r_setf   <= 1'b0;
            r_cond   <= '0;
            r_acc    <= ACC_RESET;
            r_flags  <= '0;
        end else if (clr) begin
            r_acc   <= ACC_RESET;
            r_flags <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= cmd_op;
                r_a      <= cmd_use_acc ? r_acc : cmd_a;
                r_b      <= cmd_b;
                r_wr_acc <= cmd_wr_acc;
                r_setf   <= cmd_setf;
                r_cond   <= cmd_cond;
            end
            if (w_push && r_wr_acc) r_acc   <= w_alu_res;
            if (w_push && r_setf)   r_flags <= w_alu_flags;
        end
    end

    alu32_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (clr),
        .i_push     (w_push),
        .i_push_dat ({w_alu_res, w_alu_flags, w_cond_out}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign rsp_valid  = !w_fifo_empty;
    assign rsp_result = w_head[36:5];
    assign rsp_flags  = w_head[4:1];
    assign rsp_cond   = w_head[0];
    assign acc_q      = r_acc;
    assign flags_q    = r_flags;

endmodule

// File: tb/tb_alu32_seq.sv
// Bench for alu32_seq: directed scenarios plus random traffic against a transaction-level model.
module tb_alu32_seq;

    localparam logic [31:0] ACC_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_use_acc;
    logic        cmd_wr_acc;
    logic        cmd_setf;
    logic [3:0]  cmd_cond;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_cond;
    logic [31:0] acc_q;
    logic [3:0]  flags_q;

    alu32_seq #(.FIFO_DEPTH(2), .ACC_RESET(ACC_RST)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .cmd_wr_acc  (cmd_wr_acc),
        .cmd_setf    (cmd_setf),
        .cmd_cond    (cmd_cond),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_cond    (rsp_cond),
        .acc_q       (acc_q),
        .flags_q     (flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        cnd;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] m_acc;
    logic [3:0]  m_flags;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pops = 0;
    bit          accepted;
    bit          prev_hold = 1'b0;
    logic [36:0] prev_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions: flags are {n,z,c,v}.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r = ~a;
            3'd1: r = ~b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
        endcase
        f = {r[31], r == 32'd0, c, v};
    endfunction

    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_acc     = ACC_RST;
        m_flags   = 4'h0;
        prev_hold = 1'b0;
    endtask

    task automatic model_accept();
        logic [31:0] a, r;
        logic [3:0]  f;
        rsp_t        e;
        a = cmd_use_acc ? m_acc : cmd_a;
        ref_alu(cmd_op, a, cmd_b, r, f);
        e.res = r;
        e.fl  = f;
        e.cnd = ref_cond(cmd_cond, cmd_setf ? f : m_flags);
        exp_q.push_back(e);
        if (cmd_wr_acc) m_acc = r;
        if (cmd_setf)   m_flags = f;
    endtask

    // One cycle: called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        rsp_t e;
        #1;
        if (prev_hold) chk("hold_stable", {27'd0, rsp_result[31:27], rsp_flags, rsp_cond} ^ {27'd0, prev_dat[36:32], 5'd0}, {27'd0, 5'd0, prev_dat[4:0]});
        if (prev_hold) chk("hold_result", rsp_result, prev_dat[36:5]);
        if (cmd_ready) begin
            chk("idle_acc", acc_q, m_acc);
            chk("idle_flags", {28'd0, flags_q}, {28'd0, m_flags});
            chk("idle_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
        end
        if (rsp_valid && rsp_ready && !clr) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.fl});
                chk("rsp_cond", {31'd0, rsp_cond}, {31'd0, e.cnd});
            end
        end
        accepted = cmd_valid && cmd_ready;
        if (accepted) model_accept();
        if (clr) model_reset();
        prev_hold = rsp_valid && !rsp_ready && !clr;
        prev_dat  = {rsp_result, rsp_flags, rsp_cond};
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ua, input logic wa, input logic sf, input logic [3:0] cc);
        bit got;
        got = 1'b0;
        cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_use_acc = ua; cmd_wr_acc = wa; cmd_setf = sf; cmd_cond = cc;
        cmd_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            got = accepted;
        end
        cmd_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Entered at a negedge; drops reset mid-cycle and releases it on the following negedge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        chk("rst_rsp_cond", {31'd0, rsp_cond}, 32'd0);
        chk("rst_acc", acc_q, ACC_RST);
        chk("rst_flags", {28'd0, flags_q}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 3);
            1: return 32'h7FFF_FFFE + $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; clr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
        cmd_wr_acc = 1'b0; cmd_setf = 1'b0; cmd_cond = '0;
        @(negedge clk);
        do_reset();

        // SUB 5-5 with EQ: first response latency and flag update.
        send(3'd7, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 4'h0);
        #1 chk("lat_edge_T", {31'd0, rsp_valid}, 32'd0);
        tick();
        #1;
        chk("lat_edge_T1", {31'd0, rsp_valid}, 32'd1);
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_flags", {28'd0, rsp_flags}, 32'h6);
        chk("sub_cond", {31'd0, rsp_cond}, 32'd1);
        chk("sub_flags_q", {28'd0, flags_q}, 32'h6);
        rsp_ready = 1'b1;
        idle(2);

        // Signed overflow then GE from the stored flags.
        send(3'd6, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 4'h6);
        idle(2);
        chk("ovf_flags_q", {28'd0, flags_q}, 32'h9);
        send(3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'hA);
        idle(3);

        // Accumulator chaining.
        do_reset();
        send(3'd6, 32'hDEAD_BEEF, 32'd10, 1'b1, 1'b1, 1'b0, 4'hE);
        send(3'd6, 32'hDEAD_BEEF, 32'd20, 1'b1, 1'b1, 1'b0, 4'hE);
        idle(3);
        chk("acc_chain", acc_q, 32'd30);

        // Backpressure: two fill the FIFO, the third holds in EXEC.
        rsp_ready = 1'b0;
        send(3'd4, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 4'hE);
        send(3'd7, 32'd3, 32'd9, 1'b0, 1'b0, 1'b0, 4'h3);
        send(3'd0, 32'hAAAA_0000, 32'd0, 1'b0, 1'b0, 1'b0, 4'h4);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        n_pops = 0;
        rsp_ready = 1'b1;
        idle(8);
        chk("stall_pops", n_pops, 32'd3);
        chk("stall_drained", exp_q.size(), 32'd0);

        // setf=0 condition judged on stored flags 4'b1000.
        send(3'd3, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1, 4'hE);
        idle(2);
        send(3'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'h4);
        idle(3);
        chk("mi_flags_q", {28'd0, flags_q}, 32'h8);

        // clr in EXEC with one entry queued.
        rsp_ready = 1'b0;
        send(3'd6, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 4'hE);
        idle(1);
        send(3'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b1, 4'hE);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("clr_acc", acc_q, ACC_RST);
        chk("clr_flags", {28'd0, flags_q}, 32'd0);
        chk("clr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        idle(2);

        // reset_n in EXEC discards the command.
        send(3'd6, 32'd0, 32'd99, 1'b0, 1'b1, 1'b0, 4'hE);
        idle(1);
        send(3'd6, 32'd0, 32'd5, 1'b1, 1'b1, 1'b1, 4'hE);
        do_reset();
        @(negedge clk);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid   = ($urandom_range(0, 3) != 0);
            cmd_op      = 3'($urandom_range(0, 7));
            cmd_a       = rnd_opnd();
            cmd_b       = rnd_opnd();
            cmd_use_acc = 1'($urandom_range(0, 1));
            cmd_wr_acc  = 1'($urandom_range(0, 1));
            cmd_setf    = 1'($urandom_range(0, 1));
            cmd_cond    = 4'($urandom_range(0, 15));
            rsp_ready   = ($urandom_range(0, 3) != 0);
            clr         = ($urandom_range(0, 79) == 0);
            tick();
        end
        clr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        idle(10);
        chk("final_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
